reg_wr_arbiter: RTL
===================

Name: reg_wr_arbiter

Overview:
- Round-robin write arbiter that shares a bank of NREG loadable/clearable W-bit registers between N requesters.
- Each cycle it grants at most one requester and drives that register's one-hot load or clear strobe plus the shared data bus.
- It sits between requesting agents and the register bank's ld/clr/d inputs.
- Out-of-range addresses are rejected with a per-requester error pulse.

Parameters:
- N, 4, number of requesters (2..8).
- NREG, 4, number of registers in the bank (1..2**AW).
- W, 8, register data width.
- AW, 3, per-requester address width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request per requester; held until its gnt bit is seen.
- clr_req  input  N  qualifies req: 1 = clear target register, 0 = load it.
- addr  input  N*AW  target register index; requester i uses bits [i*AW +: AW].
- wdata  input  N*W  write data; requester i uses bits [i*W +: W].
- gnt  output  N  one-cycle grant pulse, one-hot or zero.
- err  output  N  one-cycle error pulse, coincident with gnt, when addr >= NREG.
- reg_ld  output  NREG  one-hot load strobe to the register bank.
- reg_clr  output  NREG  one-hot clear strobe to the register bank.
- reg_d  output  W  data to the register bank.

Behaviour:
- Reset (async, immediate):
  - gnt, err, reg_ld, reg_clr and reg_d are all 0.
  - Priority pointer ptr = 0.
- Eligibility:
  - eligible = req & ~gnt.
  - A requester whose gnt is high in the current cycle is never regranted on the next edge, so a held req gets exactly one grant per pulse.
- Arbitration (combinational from eligible and ptr):
  - winner = first eligible index scanning ptr, ptr+1, …, wrapping modulo N.
  - If none is eligible, there is no winner.
- On each rising edge with a winner k:
  - gnt <= one-hot(k) and ptr <= (k+1) mod N, with wrap from N-1 to 0.
  - reg_d <= wdata[k].
  - If addr[k] < NREG and clr_req[k]=1: reg_clr <= one-hot(addr[k]), reg_ld <= 0.
  - If addr[k] < NREG and clr_req[k]=0: reg_ld <= one-hot(addr[k]), reg_clr <= 0.
  - If addr[k] >= NREG: err[k] <= 1, reg_ld <= 0, reg_clr <= 0. The grant is still issued and ptr still advances.
- On each rising edge with no winner:
  - gnt, err, reg_ld and reg_clr are all 0.
  - reg_d and ptr hold.
- Latency:
  - A req sampled at edge e gives gnt and strobe high from e to e+1.
  - The register bank captures at edge e+1.
  - Best-case throughput is one write per cycle.
  - Worst-case wait for a continuously requesting agent is N-1 grant cycles, so there is no starvation.
- Mutual exclusion:
  - At most one bit across reg_ld|reg_clr is high.
  - gnt is never more than one-hot.
  - err is a subset of gnt.
- Simultaneous events:
  - clr_req with req selects clear only; load and clear are never issued together.
  - Several requesters targeting the same register are serialized in round-robin order; the last one granted wins.
- Inputs are sampled only for the winner at the arbitration edge; changes after grant are ignored.
- Reset mid-operation: any in-flight strobe is dropped immediately, and pending reqs are rearbitrated from ptr=0 after rst falls.

Test Plan:
- Reset, then a single load: rst=1 for 2 cycles then 0; req=0001, addr0=2, wdata0=8'hA5. Required: gnt=0001 and reg_ld=0100 for exactly one cycle, reg_d=8'hA5, err=0.
- All-request rotation: req=1111 held and re-asserted after each gnt. Required: gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; no cycle without a grant.
- Clear priority: req=0100, clr_req=0100, addr2=1, wdata2=8'hFF. Required: reg_clr=0010, reg_ld=0000, gnt=0100.
- Out-of-range address: req=0010, addr1=5. Required: gnt=0010 and err=0010 for one cycle; reg_ld=reg_clr=0; ptr advanced so the next req=0011 grants 0001 before 0010.
- Same-target collision: req0 and req3 both load addr=3 with data 8'h11 and 8'h22, ptr=3. Required: grant 1000 with reg_d=8'h22, then grant 0001 with reg_d=8'h11 on the next cycle.
- Reset mid-write: assert rst while reg_ld=0001. Required: reg_ld, gnt and reg_d clear to 0 in the same cycle; after release with req=0110 held, the first grant is 0010.

Source files
------------

// File: rtl/reg_wr_arbiter.sv
// Round-robin write arbiter: shares a bank of NREG loadable/clearable W-bit
// registers between N requesters. At most one requester is granted per
// cycle. The grant drives a one-hot load or clear strobe and the shared data
// bus for exactly one cycle. Out-of-range targets are granted without a
// strobe and flagged with a per-requester error pulse.
//
// Handshake: a requester holds req[i] (with clr_req/addr/wdata stable) until
// it sees gnt[i] high for one cycle. Payload is sampled only at the granting
// edge. A requester whose gnt is high is ineligible at the following edge, so
// a req still high after its grant counts as a fresh request.
module reg_wr_arbiter #(
    parameter int N    = 4,
    parameter int NREG = 4,
    parameter int W    = 8,
    parameter int AW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    clr_req,
    input  logic [N*AW-1:0] addr,
    input  logic [N*W-1:0]  wdata,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    err,
    output logic [NREG-1:0] reg_ld,
    output logic [NREG-1:0] reg_clr,
    output logic [W-1:0]    reg_d
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    // Bank size widened by one bit so NREG == 2**AW is representable.
    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    err_q, err_d;
    logic [NREG-1:0] ld_q, ld_d;
    logic [NREG-1:0] clr_q, clr_d;
    logic [W-1:0]    d_q, d_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic [N-1:0]    eligible;
    logic            win_vld;
    logic [PW-1:0]   win_idx;
    logic [AW-1:0]   win_addr;
    logic            win_clr;
    logic [W-1:0]    win_data;
    logic            in_range;
    logic [N-1:0]    gnt_oh;
    logic [NREG-1:0] reg_oh;

    assign eligible = req & ~gnt_q;

    // Round-robin scan: first eligible index starting at ptr, wrapping mod N.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < N; k++) begin
                if (!win_vld && eligible[k] && (((int'(ptr_q) + s) % N) == k)) begin
                    win_vld = 1'b1;
                    win_idx = PW'(k);
                end
            end
        end
    end

    // Select the winner's payload and decode grant and register one-hots.
    always_comb begin
        win_addr = '0;
        win_clr  = 1'b0;
        win_data = '0;
        gnt_oh   = '0;
        for (int k = 0; k < N; k++) begin
            if (win_idx == PW'(k)) begin
                win_addr = addr[k*AW +: AW];
                win_clr  = clr_req[k];
                win_data = wdata[k*W +: W];
            end
            gnt_oh[k] = win_vld && (win_idx == PW'(k));
        end
        in_range = ({1'b0, win_addr} < NREG_W);
        reg_oh   = '0;
        for (int r = 0; r < NREG; r++) begin
            reg_oh[r] = ({1'b0, win_addr} == (AW+1)'(r));
        end
    end

    // Next-state: strobes pulse for one cycle; data bus and pointer hold when idle.
    always_comb begin
        gnt_d = '0;
        err_d = '0;
        ld_d  = '0;
        clr_d = '0;
        d_d   = d_q;
        ptr_d = ptr_q;
        if (win_vld) begin
            gnt_d = gnt_oh;
            d_d   = win_data;
            ptr_d = (win_idx == PW'(N-1)) ? '0 : win_idx + PW'(1);
            if (!in_range) begin
                err_d = gnt_oh;
            end else if (win_clr) begin
                clr_d = reg_oh;
            end else begin
                ld_d = reg_oh;
            end
        end
    end

    // State registers; reset drops any in-flight strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q <= '0;
            err_q <= '0;
            ld_q  <= '0;
            clr_q <= '0;
            d_q   <= '0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            err_q <= err_d;
            ld_q  <= ld_d;
            clr_q <= clr_d;
            d_q   <= d_d;
            ptr_q <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign err     = err_q;
    assign reg_ld  = ld_q;
    assign reg_clr = clr_q;
    assign reg_d   = d_q;

endmodule
